// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - C2 line-bus initiator: one cache line request becomes BEATS bus beats
//
// Ports:
//   clk, reset         clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready  line request handshake from the cache (ready only when idle)
//   req_write          1 = write line, 0 = read line
//   req_addr           line address
//   req_wdata          line to write, little-endian beats
//   resp_valid         one-cycle completion pulse
//   resp_rdata         last line read, held until the next read completes
//   mem_address        line address presented to memory
//   mem_data           shared tri-state beat bus
//   mem_command        C2_NOP / C2_READ / C2_WRITE (C2_RESPONSE is never driven)
`timescale 1ns/1ps
module mem_bus_master #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int CACHE_LINE_SIZE   = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       req_valid,
  input  logic                                       req_write,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] req_addr,
  input  logic [CACHE_LINE_SIZE*8-1:0]               req_wdata,
  output logic                                       req_ready,
  output logic                                       resp_valid,
  output logic [CACHE_LINE_SIZE*8-1:0]               resp_rdata,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
  inout  wire  [BUS_SIZE-1:0]                        mem_data,
  output logic [1:0]                                 mem_command
);

  localparam int LINE_BITS = CACHE_LINE_SIZE * 8;
  localparam int BEATS     = LINE_BITS / BUS_SIZE;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] C2_NOP   = 2'd0;
  localparam logic [1:0] C2_READ  = 2'd2;
  localparam logic [1:0] C2_WRITE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                          state;
  logic [BEAT_W-1:0]               beat;
  logic                            is_write;
  logic [LINE_BITS-1:0]            wbuf;
  // Only BEATS-1 slots are buffered; the final slot is still on the bus
  // when the line is committed at the end of GAP.
  logic [(BEATS-1)*BUS_SIZE-1:0]   rbuf;
  logic [BEAT_W-1:0]               prev_beat;
  logic [LINE_BITS-1:0]            rline;

  assign prev_beat = beat - 1'b1;
  assign rline     = {mem_data, rbuf};

  // The master owns the bus only while writing; memory drives it after READ edges.
  assign mem_data = (state == S_WRITE) ? wbuf[beat*BUS_SIZE +: BUS_SIZE] : {BUS_SIZE{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      beat        <= '0;
      is_write    <= 1'b0;
      wbuf        <= '0;
      rbuf        <= '0;
      mem_command <= C2_NOP;
      mem_address <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      req_ready   <= 1'b1;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr;
            wbuf        <= req_wdata;
            is_write    <= req_write;
            beat        <= '0;
            req_ready   <= 1'b0;
            if (req_write) begin
              state       <= S_WRITE;
              mem_command <= C2_WRITE;
            end else begin
              state       <= S_READ;
              mem_command <= C2_READ;
            end
          end
        end
        S_WRITE: begin
          if (beat == LAST_BEAT) begin
            state       <= S_GAP;
            mem_command <= C2_NOP;
            beat        <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_READ: begin
          // Memory answers one cycle behind the command, so slot beat-1 is on the bus now.
          if (beat != '0) begin
            rbuf[prev_beat*BUS_SIZE +: BUS_SIZE] <= mem_data;
          end
          if (beat == LAST_BEAT) begin
            state       <= S_GAP;
            mem_command <= C2_NOP;
            beat        <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        S_GAP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b1;
          req_ready  <= 1'b1;
          if (!is_write) begin
            resp_rdata <= rline;
          end
        end
        default: begin
          state       <= S_IDLE;
          mem_command <= C2_NOP;
          req_ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - scoreboard bench for mem_bus_master with a bus-side memory model
`timescale 1ns/1ps
module tb_mem_bus_master;

  localparam int LA    = 15;
  localparam int LB    = 128;
  localparam int BUS   = 16;
  localparam int BEATS = 8;
  localparam int LAT   = BEATS + 2;

  typedef logic [LB-1:0] line_t;
  typedef struct {
    line_t rdata;
    int    acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [LA-1:0] req_addr = '0;
  line_t         req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  line_t         resp_rdata;
  logic [LA-1:0] mem_address;
  wire  [BUS-1:0] mem_data;
  logic [1:0]    mem_command;

  always #5 clk = ~clk;

  mem_bus_master dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_command(mem_command)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input line_t act, input line_t exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic line_t default_line(input logic [LA-1:0] a);
    logic [31:0] h;
    h = {17'd0, a} * 32'h9E37_79B1;
    return {h, h ^ 32'h1111_1111, h ^ 32'h2222_2222, h ^ 32'h3333_3333};
  endfunction

  function automatic line_t rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Bus-side memory: answers each C2_READ edge with the next beat, stores C2_WRITE
  // beats, and rewinds its beat pointer on any NOP.
  line_t          bus_mem [0:(1<<LA)-1];
  logic           mdrv_en = 1'b0;
  logic [BUS-1:0] mdrv = '0;
  int             mptr = 0;

  assign mem_data = mdrv_en ? mdrv : {BUS{1'bz}};

  always @(posedge clk) begin
    if (mem_command == 2'd2) begin
      mdrv    <= bus_mem[mem_address][mptr*BUS +: BUS];
      mdrv_en <= 1'b1;
      mptr    <= (mptr + 1) % BEATS;
    end else if (mem_command == 2'd3) begin
      bus_mem[mem_address][mptr*BUS +: BUS] <= mem_data;
      mdrv_en <= 1'b0;
      mptr    <= (mptr + 1) % BEATS;
    end else begin
      mdrv_en <= 1'b0;
      mptr    <= 0;
    end
  end

  // Reference model: the line each address should hold, and what resp_rdata should show.
  line_t         ref_mem [0:(1<<LA)-1];
  line_t         last_rdata = '0;
  exp_t          exp_q[$];
  logic [LA-1:0] exp_addr = '0;
  line_t         exp_wline = '0;
  int            busy_acc = -100;
  bit            aborted = 1'b0;

  // Monitor: pops the scoreboard on resp_valid and watches the bus every cycle.
  initial begin
    logic [1:0] prev_cmd;
    int         run;
    int         wbeat;
    exp_t       e;
    prev_cmd = 2'd0;
    run      = 0;
    wbeat    = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("resp_unexpected", 1'b0, line_t'(resp_valid), line_t'(0));
          end else begin
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata == e.rdata, resp_rdata, e.rdata);
            chk("latency", (cyc - e.acc) == LAT, line_t'(cyc - e.acc), line_t'(LAT));
            chk("ready_at_resp", req_ready == 1'b1, line_t'(req_ready), line_t'(1));
          end
        end
        if (cyc > busy_acc && cyc < busy_acc + LAT) begin
          chk("ready_busy", req_ready == 1'b0, line_t'(req_ready), line_t'(0));
        end
      end
      if (mem_command == 2'd2 || mem_command == 2'd3) begin
        if (prev_cmd != 2'd0 && prev_cmd != mem_command) begin
          chk("nop_between", 1'b0, line_t'(mem_command), line_t'(0));
        end
        chk("mem_address", mem_address == exp_addr, line_t'(mem_address), line_t'(exp_addr));
        if (mem_command == 2'd3) begin
          chk("no_contention", mdrv_en == 1'b0, line_t'(mdrv_en), line_t'(0));
          if (wbeat < BEATS) begin
            chk("write_beat", mem_data === exp_wline[wbeat*BUS +: BUS],
                line_t'(mem_data), line_t'(exp_wline[wbeat*BUS +: BUS]));
          end else begin
            chk("write_overrun", 1'b0, line_t'(wbeat), line_t'(BEATS - 1));
          end
          wbeat++;
        end
        run++;
      end else begin
        if (prev_cmd != 2'd0 && !aborted) begin
          chk("run_len", run == BEATS, line_t'(run), line_t'(BEATS));
        end
        run     = 0;
        wbeat   = 0;
        aborted = 1'b0;
      end
      prev_cmd = mem_command;
    end
  end

  // Presents one request and waits (bounded) for acceptance; returns at the
  // negedge after the accepting edge. hold keeps req_valid high for a follow-on request.
  task automatic issue(input bit wr, input logic [LA-1:0] a, input line_t d,
                       input bit hold, output int acc);
    exp_t e;
    int   n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    acc = -1;
    while (!req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 1'b0, line_t'(n), line_t'(60));
      req_valid = 1'b0;
    end else begin
      acc = cyc;
      if (wr) begin
        ref_mem[a] = d;
        e.rdata    = last_rdata;
      end else begin
        e.rdata    = ref_mem[a];
        last_rdata = ref_mem[a];
      end
      e.acc     = acc;
      exp_addr  = a;
      exp_wline = d;
      busy_acc  = acc;
      exp_q.push_back(e);
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
    end
  endtask

  initial begin
    int    a1;
    int    a2;
    int    n;
    line_t wl;
    line_t l5;
    for (int i = 0; i < (1 << LA); i++) begin
      bus_mem[i] = default_line(LA'(i));
      ref_mem[i] = default_line(LA'(i));
    end
    l5 = 128'h0F0E0D0C0B0A09080706050403020100;
    bus_mem[5] = l5;
    ref_mem[5] = l5;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready == 1'b1, line_t'(req_ready), line_t'(1));
    chk("rst_resp_valid", resp_valid == 1'b0, line_t'(resp_valid), line_t'(0));
    chk("rst_mem_command", mem_command == 2'd0, line_t'(mem_command), line_t'(0));
    chk("rst_mem_address", mem_address == '0, line_t'(mem_address), line_t'(0));
    chk("rst_resp_rdata", resp_rdata == '0, resp_rdata, line_t'(0));
    reset = 1'b1;
    @(negedge clk);

    // Read of the known line at 0x05
    issue(1'b0, LA'(5), '0, 1'b0, a1);

    // Write 0x7FFF then read it back
    wl = {rand_line() & {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0}} | line_t'(32'hDEADBEEF);
    issue(1'b1, LA'(15'h7FFF), wl, 1'b0, a1);
    issue(1'b0, LA'(15'h7FFF), '0, 1'b0, a1);

    // Two reads queued back to back
    issue(1'b0, LA'(5), '0, 1'b1, a1);
    issue(1'b0, LA'(15'h7FFF), '0, 1'b0, a2);
    chk("back_to_back", (a2 - a1) == LAT, line_t'(a2 - a1), line_t'(LAT));

    // Reset during write beat 4; the aborted line 0x2AA is never read again
    issue(1'b1, LA'(15'h02AA), rand_line(), 1'b0, a1);
    while (cyc < a1 + 5) @(negedge clk);
    aborted = 1'b1;
    reset = 1'b0;
    #1;
    chk("abort_mem_command", mem_command == 2'd0, line_t'(mem_command), line_t'(0));
    chk("abort_resp_valid", resp_valid == 1'b0, line_t'(resp_valid), line_t'(0));
    chk("abort_req_ready", req_ready == 1'b1, line_t'(req_ready), line_t'(1));
    chk("abort_resp_rdata", resp_rdata == '0, resp_rdata, line_t'(0));
    exp_q.delete();
    last_rdata = '0;
    busy_acc   = -100;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(1'b0, LA'(5), '0, 1'b0, a1);

    // Request inputs toggled mid-transfer must not disturb it
    wl = rand_line();
    issue(1'b1, LA'(15'h0155), wl, 1'b0, a1);
    for (int i = 0; i < 9; i++) begin
      req_addr  = LA'($urandom);
      req_wdata = rand_line();
      req_write = 1'(($urandom));
      @(negedge clk);
    end
    issue(1'b0, LA'(15'h0155), '0, 1'b0, a1);

    // Randomized traffic over a small address window
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), LA'(15'h0100 + $urandom_range(0, 15)), rand_line(),
            (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0, a1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 1'b0, line_t'(exp_q.size()), line_t'(0));
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
